conv_apb_ctrl: RTL and testbench
================================

CONV_APB_CTRL -- requirements
Module: conv_apb_ctrl

Interface
REQ-001 SHALL have parameter NUM_HS, default 4, meaning number of handshake channels (1..16).
REQ-002 SHALL have parameter CH_W, default 9, meaning InCh/OutCh width.
REQ-003 SHALL have parameter FLEN_W, default 6, meaning FLength width.
REQ-004 SHALL have parameter ADDR_W, default 8, meaning decoded PADDR width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: PCLK in 1, rising-edge clock; PRESETB in 1, 0 = reset.
REQ-006 SHALL have APB ports: PADDR in ADDR_W; PSEL in 1; PENABLE in 1; PWRITE in 1; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERR out 1.
REQ-007 SHALL have core ports: conv_start out 1, one-cycle start pulse; COMMAND out 3, latched command; conv_done in 1, level, core finished.
REQ-008 SHALL have shape ports: InCh out CH_W; OutCh out CH_W; FLength out FLEN_W.
REQ-009 SHALL have handshake ports: hs_req in NUM_HS, core request levels; hs_ack out NUM_HS, CPU responses.
REQ-010 SHALL have irq out 1, level interrupt.

Function
REQ-011 SHALL treat access = PSEL&PENABLE, tie PREADY=1 (zero wait), decode word address PADDR[ADDR_W-1:2].
REQ-012 SHALL implement map: 0x00 CMD W; 0x04 InCh RW; 0x08 OutCh RW; 0x0C FLength RW; 0x10 HS_ACK RW; 0x14 HS_STAT RO/W1C; 0x18 IRQ_EN RW (bits NUM_HS:0); 0x1C CYCLES RO; 0x20 STATUS RO {29'b0, done_flag, busy, conv_done}; 0x24 ID RO = {16'hC0A2, 8'b0, NUM_HS[7:0]}.
REQ-013 SHALL drive PRDATA combinationally in read access phase only, zero-extended, else 0; CMD reads 0.
REQ-014 SHALL assert PSLVERR in access phase for unmapped address, write to RO register (0x1C/0x20/0x24), CMD value >4, or CMD 1..4 while busy; erroring access SHALL change no state.
REQ-015 SHALL truncate RW writes to register width.
REQ-016 SHALL run FSM IDLE->BUSY on accepted CMD 1..4: COMMAND<=value, conv_start=1 for exactly the next cycle, CYCLES<=0, done_flag<=0.
REQ-017 SHALL in BUSY increment CYCLES each cycle, saturating at 32'hFFFFFFFF; BUSY->IDLE when conv_done=1, setting done_flag; CYCLES holds in IDLE.
REQ-018 SHALL treat CMD 0 as soft reset from any state: FSM IDLE, COMMAND/InCh/OutCh/FLength/HS_ACK/HS_STAT/done_flag/CYCLES to 0, IRQ_EN kept.
REQ-019 SHALL set HS_STAT[i] on rising edge of hs_req[i] (one-cycle registered history); W1C clears; set wins over simultaneous clear.
REQ-020 SHALL clear done_flag by writing 1 to HS_STAT bit NUM_HS; conv_done set wins over simultaneous clear.
REQ-021 SHALL drive irq = |({done_flag, HS_STAT} & IRQ_EN), registered (one cycle after cause).
REQ-022 SHALL give conv_done in the same cycle as an accepted CMD no effect (IDLE state samples CMD only).

Reset
REQ-023 SHALL on PRESETB=0 immediately clear all registers, FSM IDLE, req history 0; conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq, PSLVERR-state all 0; reset mid-BUSY SHALL abort without conv_start or irq.

Verification
REQ-024 Write InCh=0x3FF, OutCh=64, FLength=0x7F, CMD=1 -> InCh=0x1FF, OutCh=64, FLength=0x3F, conv_start high one cycle, COMMAND=1, STATUS=0x2.
REQ-025 BUSY 10 cycles then conv_done=1 -> CYCLES=10, STATUS bit2=1, irq=1 next cycle if IRQ_EN[NUM_HS]=1; write 0x10 to 0x14 -> irq=0.
REQ-026 CMD=3 while busy, CMD=5, read 0x40, write 0x1C -> PSLVERR=1 each, COMMAND unchanged.
REQ-027 hs_req[2] 0->1 with IRQ_EN=0x4 -> HS_STAT=0x4, irq=1; W1C 0x4 same cycle as new hs_req[2] edge -> HS_STAT stays 0x4.
REQ-028 PRESETB low mid-BUSY -> all outputs 0, STATUS=0, ID=0xC0A20004 after release.
REQ-029 CMD=0 with IRQ_EN=0x1F, done_flag=1 -> done_flag=0, irq=0, IRQ_EN reads 0x1F.

Source files
------------

// File: rtl/conv_apb_ctrl_if.sv
// APB bus bundle between the CPU-side master and the convolution core controller.
// Signal names follow the AMBA APB naming used by the rest of the subsystem.
interface conv_apb_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/conv_apb_ctrl.sv
// APB register block that launches convolution commands, counts busy cycles,
// latches handshake request edges and raises a maskable level interrupt.
module conv_apb_ctrl #(
  parameter int unsigned NUM_HS = 4,
  parameter int unsigned CH_W   = 9,
  parameter int unsigned FLEN_W = 6,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                PCLK,
  input  logic                PRESETB,
  conv_apb_ctrl_if.slave      apb,
  output logic                conv_start,
  output logic [2:0]          COMMAND,
  input  logic                conv_done,
  output logic [CH_W-1:0]     InCh,
  output logic [CH_W-1:0]     OutCh,
  output logic [FLEN_W-1:0]   FLength,
  input  logic [NUM_HS-1:0]   hs_req,
  output logic [NUM_HS-1:0]   hs_ack,
  output logic                irq
);

  localparam int unsigned WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] A_CMD    = WA_W'(0);
  localparam logic [WA_W-1:0] A_INCH   = WA_W'(1);
  localparam logic [WA_W-1:0] A_OUTCH  = WA_W'(2);
  localparam logic [WA_W-1:0] A_FLEN   = WA_W'(3);
  localparam logic [WA_W-1:0] A_HSACK  = WA_W'(4);
  localparam logic [WA_W-1:0] A_HSSTAT = WA_W'(5);
  localparam logic [WA_W-1:0] A_IRQEN  = WA_W'(6);
  localparam logic [WA_W-1:0] A_CYCLES = WA_W'(7);
  localparam logic [WA_W-1:0] A_STATUS = WA_W'(8);
  localparam logic [WA_W-1:0] A_ID     = WA_W'(9);
  localparam logic [7:0]      NUM_HS_B = 8'(NUM_HS);
  localparam logic [31:0]     ID_VAL   = {16'hC0A2, 8'h00, NUM_HS_B};

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q;
  logic [2:0]          command_q;
  logic                start_q;
  logic [CH_W-1:0]     inch_q, outch_q;
  logic [FLEN_W-1:0]   flen_q;
  logic [NUM_HS-1:0]   hs_ack_q, hs_stat_q, hs_req_q;
  logic [NUM_HS:0]     irq_en_q;
  logic                done_flag_q;
  logic [31:0]         cycles_q;
  logic                irq_q;

  logic [WA_W-1:0]     waddr;
  logic                access, mapped, read_only, cmd_bad, err;
  logic                wr_ok, rd_ok, soft_rst, start_cmd;
  logic [31:0]         rdata;
  logic [NUM_HS:0]     w1c;
  logic [NUM_HS-1:0]   hs_rise;

  assign waddr  = apb.PADDR[ADDR_W-1:2];
  assign access = apb.PSEL & apb.PENABLE;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b0;
    rdata     = '0;
    case (waddr)
      A_CMD:    rdata = '0;
      A_INCH:   rdata = 32'(inch_q);
      A_OUTCH:  rdata = 32'(outch_q);
      A_FLEN:   rdata = 32'(flen_q);
      A_HSACK:  rdata = 32'(hs_ack_q);
      A_HSSTAT: rdata = 32'(hs_stat_q);
      A_IRQEN:  rdata = 32'(irq_en_q);
      A_CYCLES: begin rdata = cycles_q; read_only = 1'b1; end
      A_STATUS: begin
        rdata     = {29'b0, done_flag_q, state_q == S_BUSY, conv_done};
        read_only = 1'b1;
      end
      A_ID:     begin rdata = ID_VAL; read_only = 1'b1; end
      default:  mapped = 1'b0;
    endcase
  end

  // A new command is refused while one is in flight; CMD 0 (soft reset) is always legal.
  assign cmd_bad = apb.PWRITE && (waddr == A_CMD) &&
                   ((apb.PWDATA > 32'd4) || ((apb.PWDATA != 32'd0) && (state_q == S_BUSY)));
  assign err       = access & (~mapped | (apb.PWRITE & read_only) | cmd_bad);
  assign wr_ok     = access & apb.PWRITE & ~err;
  assign rd_ok     = access & ~apb.PWRITE & ~err;
  assign soft_rst  = wr_ok & (waddr == A_CMD) & (apb.PWDATA == 32'd0);
  assign start_cmd = wr_ok & (waddr == A_CMD) & (apb.PWDATA != 32'd0);
  assign w1c       = (wr_ok && waddr == A_HSSTAT) ? apb.PWDATA[NUM_HS:0] : '0;
  assign hs_rise   = hs_req & ~hs_req_q;

  assign apb.PRDATA  = rd_ok ? rdata : '0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      state_q     <= S_IDLE;
      command_q   <= '0;
      start_q     <= 1'b0;
      inch_q      <= '0;
      outch_q     <= '0;
      flen_q      <= '0;
      hs_ack_q    <= '0;
      hs_stat_q   <= '0;
      hs_req_q    <= '0;
      irq_en_q    <= '0;
      done_flag_q <= 1'b0;
      cycles_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      hs_req_q <= hs_req;
      start_q  <= start_cmd;
      irq_q    <= |({done_flag_q, hs_stat_q} & irq_en_q);
      if (soft_rst) begin
        state_q     <= S_IDLE;
        command_q   <= '0;
        inch_q      <= '0;
        outch_q     <= '0;
        flen_q      <= '0;
        hs_ack_q    <= '0;
        hs_stat_q   <= '0;
        done_flag_q <= 1'b0;
        cycles_q    <= '0;
      end else begin
        hs_stat_q <= (hs_stat_q & ~w1c[NUM_HS-1:0]) | hs_rise;
        if (w1c[NUM_HS]) done_flag_q <= 1'b0;
        if (wr_ok) begin
          case (waddr)
            A_INCH:  inch_q   <= apb.PWDATA[CH_W-1:0];
            A_OUTCH: outch_q  <= apb.PWDATA[CH_W-1:0];
            A_FLEN:  flen_q   <= apb.PWDATA[FLEN_W-1:0];
            A_HSACK: hs_ack_q <= apb.PWDATA[NUM_HS-1:0];
            A_IRQEN: irq_en_q <= apb.PWDATA[NUM_HS:0];
            default: ;
          endcase
        end
        // CYCLES counts busy cycles before the one in which conv_done is seen.
        case (state_q)
          S_IDLE: if (start_cmd) begin
            state_q     <= S_BUSY;
            command_q   <= apb.PWDATA[2:0];
            cycles_q    <= '0;
            done_flag_q <= 1'b0;
          end
          S_BUSY: if (conv_done) begin
            state_q     <= S_IDLE;
            done_flag_q <= 1'b1;
          end else if (cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign conv_start = start_q;
  assign COMMAND    = command_q;
  assign InCh       = inch_q;
  assign OutCh      = outch_q;
  assign FLength    = flen_q;
  assign hs_ack     = hs_ack_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_conv_apb_ctrl.sv
// Bench for conv_apb_ctrl: directed scenarios plus random APB traffic, all
// checked against a cycle-level behavioural model of the register map.
module tb_conv_apb_ctrl;
  localparam int NUM_HS = 4;
  localparam int CH_W   = 9;
  localparam int FLEN_W = 6;
  localparam int ADDR_W = 8;

  logic                PCLK    = 1'b0;
  logic                PRESETB = 1'b1;
  logic                conv_start;
  logic [2:0]          COMMAND;
  logic                conv_done = 1'b0;
  logic [CH_W-1:0]     InCh, OutCh;
  logic [FLEN_W-1:0]   FLength;
  logic [NUM_HS-1:0]   hs_req = '0;
  logic [NUM_HS-1:0]   hs_ack;
  logic                irq;

  int n_checks = 0;
  int n_errors = 0;

  conv_apb_ctrl_if #(.ADDR_W(ADDR_W)) apb_if ();

  conv_apb_ctrl #(
    .NUM_HS(NUM_HS), .CH_W(CH_W), .FLEN_W(FLEN_W), .ADDR_W(ADDR_W)
  ) dut (
    .PCLK(PCLK), .PRESETB(PRESETB), .apb(apb_if.slave),
    .conv_start(conv_start), .COMMAND(COMMAND), .conv_done(conv_done),
    .InCh(InCh), .OutCh(OutCh), .FLength(FLength),
    .hs_req(hs_req), .hs_ack(hs_ack), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- behavioural reference model ----------------
  logic [CH_W-1:0]   m_inch, m_outch;
  logic [FLEN_W-1:0] m_flen;
  logic [NUM_HS-1:0] m_hsack, m_hsstat, m_prev_req;
  logic [NUM_HS:0]   m_irqen;
  logic              m_done, m_busy, m_start, m_irq;
  logic [2:0]        m_cmd;
  logic [31:0]       m_cycles;

  function automatic logic model_err();
    int wa = int'(apb_if.PADDR[7:2]);
    if (!(apb_if.PSEL && apb_if.PENABLE)) return 1'b0;
    if (wa > 9) return 1'b1;
    if (apb_if.PWRITE && wa >= 7) return 1'b1;
    if (apb_if.PWRITE && wa == 0 &&
        (apb_if.PWDATA > 4 || (apb_if.PWDATA != 0 && m_busy))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_rdata();
    int wa = int'(apb_if.PADDR[7:2]);
    if (!(apb_if.PSEL && apb_if.PENABLE) || apb_if.PWRITE || model_err()) return 32'h0;
    case (wa)
      1: return 32'(m_inch);
      2: return 32'(m_outch);
      3: return 32'(m_flen);
      4: return 32'(m_hsack);
      5: return 32'(m_hsstat);
      6: return 32'(m_irqen);
      7: return m_cycles;
      8: return {29'b0, m_done, m_busy, conv_done};
      9: return 32'hC0A2_0000 | 32'(NUM_HS);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge PCLK or negedge PRESETB) begin
    int wa;
    logic wr_ok, nxt_irq, done_evt;
    logic [NUM_HS-1:0] rises;
    if (!PRESETB) begin
      m_inch = '0; m_outch = '0; m_flen = '0; m_hsack = '0; m_hsstat = '0;
      m_prev_req = '0; m_irqen = '0; m_done = 0; m_busy = 0; m_start = 0;
      m_irq = 0; m_cmd = '0; m_cycles = '0;
    end else begin
      wa       = int'(apb_if.PADDR[7:2]);
      wr_ok    = apb_if.PSEL && apb_if.PENABLE && apb_if.PWRITE && !model_err();
      nxt_irq  = |({m_done, m_hsstat} & m_irqen);
      rises    = hs_req & ~m_prev_req;
      m_prev_req = hs_req;
      m_start  = 0;
      done_evt = 0;
      if (wr_ok && wa == 0 && apb_if.PWDATA == 0) begin
        m_busy = 0; m_cmd = '0; m_inch = '0; m_outch = '0; m_flen = '0;
        m_hsack = '0; m_hsstat = '0; m_done = 0; m_cycles = '0;
      end else begin
        if (m_busy) begin
          if (conv_done) begin m_busy = 0; done_evt = 1; end
          else if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        end
        if (wr_ok) begin
          case (wa)
            0: begin m_busy = 1; m_cmd = apb_if.PWDATA[2:0]; m_start = 1; m_cycles = 0; m_done = 0; end
            1: m_inch  = apb_if.PWDATA[CH_W-1:0];
            2: m_outch = apb_if.PWDATA[CH_W-1:0];
            3: m_flen  = apb_if.PWDATA[FLEN_W-1:0];
            4: m_hsack = apb_if.PWDATA[NUM_HS-1:0];
            5: begin
              m_hsstat = m_hsstat & ~apb_if.PWDATA[NUM_HS-1:0];
              if (apb_if.PWDATA[NUM_HS]) m_done = 0;
            end
            6: m_irqen = apb_if.PWDATA[NUM_HS:0];
            default: ;
          endcase
        end
        m_hsstat = m_hsstat | rises;
        if (done_evt) m_done = 1;
      end
      m_irq = nxt_irq;
    end
  end

  // ---------------- APB master ----------------
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [NUM_HS-1:0] hs_acc,
                      output logic [31:0] rdata, output logic err,
                      output logic [31:0] exp_rdata, output logic exp_err);
    @(negedge PCLK);
    apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PWRITE = wr;
    apb_if.PADDR = addr; apb_if.PWDATA = wdata;
    @(negedge PCLK);
    apb_if.PENABLE = 1'b1;
    hs_req = hs_acc;
    #1;
    rdata = apb_if.PRDATA; err = apb_if.PSLVERR;
    exp_rdata = model_rdata(); exp_err = model_err();
    @(negedge PCLK);
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd, erd; logic e, ee;
    apb_if.PSEL = 0; apb_if.PENABLE = 0; apb_if.PWRITE = 0; apb_if.PADDR = '0; apb_if.PWDATA = '0;
    #2 PRESETB = 1'b0;
    #3;
    n_checks++;
    if ({conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", {conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq});
    end
    @(negedge PCLK); PRESETB = 1'b1;
    xfer(0, 8'h24, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'hC0A2_0004 || e !== 1'b0) begin
      n_errors++; $display("FAIL reset_id: got %h err %b expected C0A20004 err 0", rd, e);
    end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_status: got %h expected 0", rd); end
  endtask

  task automatic test_shape_regs();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h04, 32'h3FF, hs_req, rd, e, erd, ee);
    xfer(1, 8'h08, 32'd64,  hs_req, rd, e, erd, ee);
    xfer(1, 8'h0C, 32'h7F,  hs_req, rd, e, erd, ee);
    xfer(1, 8'h10, 32'h1F,  hs_req, rd, e, erd, ee);
    n_checks++;
    if (InCh !== 9'h1FF || OutCh !== 9'd64 || FLength !== 6'h3F || hs_ack !== 4'hF) begin
      n_errors++; $display("FAIL shape_truncate: got %h %h %h %h expected 1ff 040 3f f", InCh, OutCh, FLength, hs_ack);
    end
    xfer(0, 8'h04, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h1FF || rd !== erd) begin n_errors++; $display("FAIL inch_read: got %h expected 1ff", rd); end
  endtask

  task automatic test_start();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h00, 32'd1, hs_req, rd, e, erd, ee);
    n_checks++;
    if (conv_start !== 1'b1 || COMMAND !== 3'd1 || e !== 1'b0) begin
      n_errors++; $display("FAIL start_pulse: got start %b cmd %0d err %b expected 1 1 0", conv_start, COMMAND, e);
    end
    @(negedge PCLK);
    n_checks++;
    if (conv_start !== 1'b0) begin n_errors++; $display("FAIL start_one_cycle: got %b expected 0", conv_start); end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h2) begin n_errors++; $display("FAIL status_busy: got %h expected 2", rd); end
    conv_done = 1'b1; @(negedge PCLK); conv_done = 1'b0;
  endtask

  task automatic test_busy_done();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h18, 32'h10, hs_req, rd, e, erd, ee);
    xfer(1, 8'h00, 32'd2, hs_req, rd, e, erd, ee);
    repeat (10) @(negedge PCLK);
    conv_done = 1'b1;
    @(negedge PCLK);
    conv_done = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_done: got %b expected 1", irq); end
    xfer(0, 8'h1C, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'd10 || rd !== erd) begin n_errors++; $display("FAIL cycles: got %0d expected 10 (model %0d)", rd, erd); end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h4) begin n_errors++; $display("FAIL status_done: got %h expected 4", rd); end
    xfer(1, 8'h14, 32'h10, hs_req, rd, e, erd, ee);
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin n_errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic e, ee;
    conv_done = 1'b1;
    xfer(1, 8'h00, 32'd3, hs_req, rd, e, erd, ee);
    conv_done = 1'b0;
    n_checks++;
    if (e !== 1'b0 || COMMAND !== 3'd3) begin n_errors++; $display("FAIL cmd3_accept: got err %b cmd %0d expected 0 3", e, COMMAND); end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h2) begin n_errors++; $display("FAIL done_ignored_idle: got %h expected 2", rd); end
    xfer(1, 8'h00, 32'd3, hs_req, rd, e, erd, ee);
    n_checks++;
    if (e !== 1'b1) begin n_errors++; $display("FAIL err_cmd_busy: got %b expected 1", e); end
    xfer(1, 8'h00, 32'd5, hs_req, rd, e, erd, ee);
    n_checks++;
    if (e !== 1'b1) begin n_errors++; $display("FAIL err_cmd5: got %b expected 1", e); end
    xfer(0, 8'h40, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL err_unmapped: got err %b data %h expected 1 0", e, rd); end
    xfer(1, 8'h1C, 32'h0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (e !== 1'b1) begin n_errors++; $display("FAIL err_ro_write: got %b expected 1", e); end
    xfer(0, 8'h1C, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (COMMAND !== 3'd3 || rd !== erd || rd == 32'h0) begin
      n_errors++; $display("FAIL err_no_effect: got cmd %0d cycles %0d expected 3 %0d", COMMAND, rd, erd);
    end
    conv_done = 1'b1; @(negedge PCLK); conv_done = 1'b0;
  endtask

  task automatic test_handshake();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h18, 32'h4, hs_req, rd, e, erd, ee);
    @(negedge PCLK); hs_req[2] = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL hs_irq: got %b expected 1", irq); end
    xfer(0, 8'h14, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h4) begin n_errors++; $display("FAIL hs_stat_set: got %h expected 4", rd); end
    hs_req[2] = 1'b0;
    @(negedge PCLK);
    xfer(1, 8'h14, 32'h4, 4'b0100, rd, e, erd, ee);
    xfer(0, 8'h14, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h4) begin n_errors++; $display("FAIL hs_set_wins: got %h expected 4", rd); end
    xfer(1, 8'h14, 32'h4, hs_req, rd, e, erd, ee);
    xfer(0, 8'h14, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL hs_w1c: got %h expected 0", rd); end
    hs_req = '0;
  endtask

  task automatic test_soft_reset();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h18, 32'h1F, hs_req, rd, e, erd, ee);
    xfer(1, 8'h04, 32'h55, hs_req, rd, e, erd, ee);
    xfer(1, 8'h00, 32'd4, hs_req, rd, e, erd, ee);
    conv_done = 1'b1; @(negedge PCLK); conv_done = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL soft_pre_irq: got %b expected 1", irq); end
    xfer(1, 8'h00, 32'd0, hs_req, rd, e, erd, ee);
    @(negedge PCLK);
    n_checks++;
    if (irq !== 1'b0 || InCh !== '0 || COMMAND !== 3'd0) begin
      n_errors++; $display("FAIL soft_outputs: got irq %b inch %h cmd %0d expected 0 0 0", irq, InCh, COMMAND);
    end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL soft_status: got %h expected 0", rd); end
    xfer(0, 8'h18, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h1F) begin n_errors++; $display("FAIL soft_irqen_kept: got %h expected 1f", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd; logic e, ee, wr;
    logic [7:0] addrs [13];
    logic [7:0] a;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h40, 8'hFC};
    for (int i = 0; i < 120; i++) begin
      a  = addrs[$urandom_range(0, 12)];
      wr = 1'($urandom_range(0, 1));
      wd = (a == 8'h00) ? 32'($urandom_range(0, 6)) : $urandom;
      conv_done = ($urandom_range(0, 5) == 0);
      xfer(wr, a, wd, 4'($urandom), rd, e, erd, ee);
      n_checks++;
      if (e !== ee || rd !== erd) begin
        n_errors++; $display("FAIL rand_bus[%0d] addr %h wr %b: got err %b data %h expected err %b data %h", i, a, wr, e, rd, ee, erd);
      end
      n_checks++;
      if ({conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq} !==
          {m_start, m_cmd, m_inch, m_outch, m_flen, m_hsack, m_irq}) begin
        n_errors++; $display("FAIL rand_outputs[%0d]: got %h expected %h", i,
          {conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq},
          {m_start, m_cmd, m_inch, m_outch, m_flen, m_hsack, m_irq});
      end
    end
    conv_done = 1'b0;
    hs_req = '0;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd, erd; logic e, ee;
    xfer(1, 8'h00, 32'd0, hs_req, rd, e, erd, ee);
    xfer(1, 8'h18, 32'h1F, hs_req, rd, e, erd, ee);
    xfer(1, 8'h08, 32'h1AB, hs_req, rd, e, erd, ee);
    xfer(1, 8'h00, 32'd4, hs_req, rd, e, erd, ee);
    repeat (3) @(negedge PCLK);
    PRESETB = 1'b0;
    #1;
    n_checks++;
    if ({conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq, apb_if.PRDATA, apb_if.PSLVERR} !== '0) begin
      n_errors++; $display("FAIL mid_busy_reset: got %h expected 0", {conv_start, COMMAND, InCh, OutCh, FLength, hs_ack, irq});
    end
    @(negedge PCLK); PRESETB = 1'b1;
    conv_done = 1'b1; @(negedge PCLK); conv_done = 1'b0;
    n_checks++;
    if (conv_start !== 1'b0 || irq !== 1'b0) begin n_errors++; $display("FAIL post_reset_quiet: got start %b irq %b expected 0 0", conv_start, irq); end
    xfer(0, 8'h20, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL post_reset_status: got %h expected 0", rd); end
    xfer(0, 8'h24, 0, hs_req, rd, e, erd, ee);
    n_checks++;
    if (rd !== 32'hC0A2_0004) begin n_errors++; $display("FAIL post_reset_id: got %h expected c0a20004", rd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_shape_regs();
    test_start();
    test_busy_done();
    test_errors();
    test_handshake();
    test_soft_reset();
    test_random();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
